// File: rtl/hmac512_arbiter.sv
// Two-requester (bit0 CPU, bit1 KDF) round-robin arbiter in front of one HMAC-512 engine, with a
// post-job secret wipe. Define HMAC512_ARB_TIMEOUT_EN to add the busy watchdog that drives abort_o.
module hmac512_arbiter #(
  parameter int unsigned DW          = 32,
  parameter int unsigned WIPE_CYCLES = 2,
  parameter logic [31:0] WIPE_V      = 32'h0,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        req_i,
  input  logic [1:0]        start_i,
  input  logic [1:0]        process_i,
  input  logic [1:0]        hmac_en_i,
  input  logic [1:0]        wvalid_i,
  input  logic [2*DW-1:0]   wdata_i,
  input  logic [2*DW/8-1:0] wmask_i,
  output logic [1:0]        wready_o,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              eng_hmac_en_o,
  output logic              eng_start_o,
  output logic              eng_process_o,
  input  logic              eng_done_i,
  output logic              eng_wvalid_o,
  output logic [DW-1:0]     eng_wdata_o,
  output logic [DW/8-1:0]   eng_wmask_o,
  input  logic              eng_wready_i,
  output logic              eng_wipe_o,
  output logic [31:0]       eng_wipe_v_o,
  output logic              busy_o,
  output logic              owner_o,
  output logic              abort_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StBusy  = 2'd2,
    StWipe  = 2'd3
  } state_e;

  localparam logic [3:0] WIPE_LAST = 4'(WIPE_CYCLES - 1);

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic       owner_q, owner_d;
  logic       hmac_q, hmac_d;
  logic [3:0] wipe_cnt_q, wipe_cnt_d;
  logic       tmo_hit;

  logic            own_start;
  logic            own_wvalid;
  logic [DW-1:0]   own_wdata;
  logic [DW/8-1:0] own_wmask;

  assign own_start  = start_i[owner_q];
  assign own_wvalid = wvalid_i[owner_q];
  assign own_wdata  = owner_q ? wdata_i[2*DW-1:DW] : wdata_i[DW-1:0];
  assign own_wmask  = owner_q ? wmask_i[2*DW/8-1:DW/8] : wmask_i[DW/8-1:0];

`ifdef HMAC512_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] tmo_q;

  // Counts busy cycles; the count is zero on the first cycle of every job.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != StBusy) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 16'd1;
    end
  end

  assign tmo_hit = (state_q == StBusy) && (tmo_q == TMO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      hmac_q     <= 1'b0;
      wipe_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      hmac_q     <= hmac_d;
      wipe_cnt_q <= wipe_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    hmac_d     = hmac_q;
    wipe_cnt_d = wipe_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          owner_d = req_i[rr_q] ? rr_q : ~rr_q;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // An abandoned grant leaves rr_q alone so the same side keeps priority.
        if (own_start) begin
          hmac_d  = hmac_en_i[owner_q];
          state_d = StBusy;
        end else if (!req_i[owner_q]) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (eng_done_i || tmo_hit) begin
          wipe_cnt_d = '0;
          state_d    = StWipe;
        end
      end
      StWipe: begin
        if (wipe_cnt_q == WIPE_LAST) begin
          wipe_cnt_d = '0;
          rr_d       = ~owner_q;
          state_d    = StIdle;
        end else begin
          wipe_cnt_d = wipe_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stream handshake: a word moves on any cycle where eng_wvalid_o && eng_wready_i. Only the owner
  // sees the engine's ready, and only while busy; valid/data/mask pass through unregistered.
  always_comb begin
    wready_o      = 2'b00;
    gnt_o         = 2'b00;
    done_o        = 2'b00;
    eng_hmac_en_o = 1'b0;
    eng_start_o   = 1'b0;
    eng_process_o = 1'b0;
    eng_wvalid_o  = 1'b0;
    eng_wdata_o   = '0;
    eng_wmask_o   = '0;
    eng_wipe_o    = 1'b0;
    eng_wipe_v_o  = 32'h0;
    busy_o        = 1'b0;
    owner_o       = 1'b0;
    abort_o       = 1'b0;
    unique case (state_q)
      StIdle: ;
      StGrant: begin
        busy_o         = 1'b1;
        owner_o        = owner_q;
        gnt_o[owner_q] = 1'b1;
        eng_start_o    = own_start;
        eng_hmac_en_o  = own_start & hmac_en_i[owner_q];
      end
      StBusy: begin
        busy_o            = 1'b1;
        owner_o           = owner_q;
        gnt_o[owner_q]    = 1'b1;
        eng_hmac_en_o     = hmac_q;
        eng_process_o     = process_i[owner_q];
        eng_wvalid_o      = own_wvalid;
        eng_wdata_o       = own_wdata;
        eng_wmask_o       = own_wmask;
        wready_o[owner_q] = eng_wready_i;
        // A completion arriving with the watchdog expiry counts as a normal finish.
        if (eng_done_i) begin
          done_o[owner_q] = 1'b1;
        end else if (tmo_hit) begin
          abort_o = 1'b1;
        end
      end
      StWipe: begin
        busy_o        = 1'b1;
        owner_o       = owner_q;
        eng_hmac_en_o = hmac_q;
        eng_wipe_o    = 1'b1;
        eng_wipe_v_o  = WIPE_V;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_done_abort: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 !(abort_o && (done_o != 2'b00)));
  a_wipe_nogrant: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   eng_wipe_o |-> (gnt_o == 2'b00));
`endif

endmodule

// File: tb/tb_hmac512_arbiter.sv
// Bench for hmac512_arbiter: random streams and job timing checked against an arbitration model
// and a data scoreboard. Covers both builds of HMAC512_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_hmac512_arbiter;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int WIPE_CYCLES = 2;
  localparam logic [31:0] WIPE_V = 32'hA5A5_5A5A;
  localparam int TIMEOUT = 100;
  localparam logic [DW-1:0] NOISE = 32'hDEADBEEF;
  localparam int AW = 6 + 4 + DW + MW + 1 + 32 + 3 + 2;
`ifdef HMAC512_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk_i, rst_ni;
  logic [1:0]      req_i, start_i, process_i, hmac_en_i, wvalid_i;
  logic [2*DW-1:0] wdata_i;
  logic [2*MW-1:0] wmask_i;
  logic [1:0]      wready_o, gnt_o, done_o, state_o;
  logic            eng_hmac_en_o, eng_start_o, eng_process_o, eng_done_i;
  logic            eng_wvalid_o, eng_wready_i, eng_wipe_o, busy_o, owner_o, abort_o;
  logic [DW-1:0]   eng_wdata_o;
  logic [MW-1:0]   eng_wmask_o;
  logic [31:0]     eng_wipe_v_o;
  logic [AW-1:0]   all_outs;

  logic [DW+MW-1:0] exp_q[$];
  int n_cmp, n_err;
  logic rr_m;

  hmac512_arbiter #(
    .DW(DW), .WIPE_CYCLES(WIPE_CYCLES), .WIPE_V(WIPE_V), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .start_i(start_i), .process_i(process_i),
    .hmac_en_i(hmac_en_i), .wvalid_i(wvalid_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
    .wready_o(wready_o), .gnt_o(gnt_o), .done_o(done_o), .eng_hmac_en_o(eng_hmac_en_o),
    .eng_start_o(eng_start_o), .eng_process_o(eng_process_o), .eng_done_i(eng_done_i),
    .eng_wvalid_o(eng_wvalid_o), .eng_wdata_o(eng_wdata_o), .eng_wmask_o(eng_wmask_o),
    .eng_wready_i(eng_wready_i), .eng_wipe_o(eng_wipe_o), .eng_wipe_v_o(eng_wipe_v_o),
    .busy_o(busy_o), .owner_o(owner_o), .abort_o(abort_o), .state_o(state_o)
  );

  assign all_outs = {wready_o, gnt_o, done_o, eng_hmac_en_o, eng_start_o, eng_process_o,
                     eng_wvalid_o, eng_wdata_o, eng_wmask_o, eng_wipe_o, eng_wipe_v_o,
                     busy_o, owner_o, abort_o, state_o};

  // Clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    start_i = '0; process_i = '0; hmac_en_i = '0; wvalid_i = '0;
    wdata_i = '0; wmask_i = '0; eng_done_i = 1'b0; eng_wready_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    req_i = '0;
    clear_inputs();
    repeat (3) tick();
    rst_ni = 1'b1;
    rr_m = 1'b0;
    exp_q.delete();
  endtask

  // One complete job; owner, done/abort timing and wipe length come from the model.
  task automatic do_job(input logic [1:0] req, input int nwords, input int done_cycle,
                        input int grant_wait);
    logic own, oth, hm, v, rdy, p, in_wipe, finished, exp_abort;
    logic [1:0] onehot, exp_done;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
    logic [DW+MW-1:0] got, want;
    int sent, wcnt;
    bit proc_sent;
    own = req[rr_m] ? rr_m : ~rr_m;
    oth = ~own;
    onehot = 2'b01 << own;
    req_i = req;
    clear_inputs();
    #1;
    n_cmp++;
    if ({gnt_o, busy_o} !== 3'b000) begin
      n_err++; $display("FAIL idle_before_grant: gnt/busy got %b expected 000", {gnt_o, busy_o});
    end
    tick();
    #1;
    n_cmp++;
    if ({gnt_o, busy_o, owner_o} !== {onehot, 1'b1, own}) begin
      n_err++;
      $display("FAIL grant: gnt/busy/owner got %b expected %b", {gnt_o, busy_o, owner_o},
               {onehot, 1'b1, own});
    end
    for (int i = 0; i < grant_wait; i++) begin
      start_i = '0; start_i[oth] = 1'b1; wvalid_i = 2'b11; eng_wready_i = 1'b1;
      #1;
      n_cmp++;
      if ({eng_start_o, wready_o, gnt_o} !== {1'b0, 2'b00, onehot}) begin
        n_err++;
        $display("FAIL grant_wait: start/wready/gnt got %b expected %b",
                 {eng_start_o, wready_o, gnt_o}, {1'b0, 2'b00, onehot});
      end
      tick();
    end
    hm = 1'($urandom_range(0, 1));
    clear_inputs();
    start_i[own] = 1'b1; start_i[oth] = 1'($urandom_range(0, 1));
    hmac_en_i[own] = hm; hmac_en_i[oth] = ~hm;
    #1;
    n_cmp++;
    if ({eng_start_o, eng_hmac_en_o} !== {1'b1, hm}) begin
      n_err++;
      $display("FAIL start_fwd: start/hmac got %b expected %b", {eng_start_o, eng_hmac_en_o},
               {1'b1, hm});
    end
    tick();
    sent = 0; proc_sent = 0; finished = 1'b0;
    for (int k = 1; k <= 400 && !finished; k++) begin
      v = (sent < nwords) ? 1'($urandom_range(0, 1)) : 1'b0;
      d = $urandom;
      if (d == NOISE) d = '0;
      m = MW'($urandom);
      rdy = 1'($urandom_range(0, 1));
      p = (sent == nwords) && !proc_sent;
      wvalid_i[own] = v; wvalid_i[oth] = 1'($urandom_range(0, 1));
      wdata_i = own ? {d, NOISE} : {NOISE, d};
      wmask_i = own ? {m, ~m} : {~m, m};
      start_i[own] = 1'b0; start_i[oth] = 1'($urandom_range(0, 1));
      process_i[own] = p; process_i[oth] = 1'($urandom_range(0, 1));
      hmac_en_i = 2'($urandom_range(0, 3));
      eng_wready_i = rdy;
      eng_done_i = (k == done_cycle);
      if (v && rdy) begin
        exp_q.push_back({m, d});
        sent++;
      end
      if (p) proc_sent = 1;
      exp_abort = TMO_EN && (k == TIMEOUT) && (k != done_cycle);
      exp_done = (k == done_cycle) ? onehot : 2'b00;
      #1;
      n_cmp++;
      if ({done_o, abort_o} !== {exp_done, exp_abort}) begin
        n_err++;
        $display("FAIL busy_end cycle %0d: done/abort got %b expected %b", k, {done_o, abort_o},
                 {exp_done, exp_abort});
      end
      n_cmp++;
      if ({eng_start_o, eng_hmac_en_o, gnt_o, eng_process_o, eng_wvalid_o} !==
          {1'b0, hm, onehot, p, v}) begin
        n_err++;
        $display("FAIL busy_ctrl cycle %0d: got %b expected %b", k,
                 {eng_start_o, eng_hmac_en_o, gnt_o, eng_process_o, eng_wvalid_o},
                 {1'b0, hm, onehot, p, v});
      end
      n_cmp++;
      if (wready_o !== (rdy ? onehot : 2'b00)) begin
        n_err++;
        $display("FAIL wready cycle %0d: got %b expected %b", k, wready_o,
                 (rdy ? onehot : 2'b00));
      end
      n_cmp++;
      if (eng_wdata_o === NOISE) begin
        n_err++; $display("FAIL isolation: eng_wdata_o got %h expected not %h", eng_wdata_o, NOISE);
      end
      if (eng_wvalid_o && eng_wready_i) begin
        got = {eng_wmask_o, eng_wdata_o};
        want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_cmp++;
        if (got !== want) begin
          n_err++; $display("FAIL stream_word: got %h expected %h", got, want);
        end
      end
      if (exp_done != 2'b00 || exp_abort) finished = 1'b1;
      tick();
    end
    n_cmp++;
    if (!finished || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL job_end: finished/leftover got %0d/%0d expected 1/0", finished, exp_q.size());
    end
    clear_inputs();
    wcnt = 0; in_wipe = 1'b1;
    for (int i = 0; i < 20 && in_wipe; i++) begin
      #1;
      if (eng_wipe_o === 1'b1) begin
        n_cmp++;
        if ({gnt_o, done_o, abort_o, busy_o, eng_hmac_en_o, eng_wipe_v_o} !==
            {2'b00, 2'b00, 1'b0, 1'b1, hm, WIPE_V}) begin
          n_err++;
          $display("FAIL wipe: gnt/done/abort/busy/hmac/wipe_v got %b_%b_%b_%b_%b_%h", gnt_o,
                   done_o, abort_o, busy_o, eng_hmac_en_o, eng_wipe_v_o);
        end
        wcnt++;
        tick();
      end else begin
        in_wipe = 1'b0;
      end
    end
    n_cmp++;
    if (wcnt != WIPE_CYCLES) begin
      n_err++; $display("FAIL wipe_len: got %0d expected %0d", wcnt, WIPE_CYCLES);
    end
    n_cmp++;
    if ({busy_o, owner_o, eng_hmac_en_o, gnt_o, eng_wipe_v_o} !== 37'd0) begin
      n_err++;
      $display("FAIL after_job: busy/owner/hmac/gnt got %b%b%b%b wipe_v %h expected all 0",
               busy_o, owner_o, eng_hmac_en_o, gnt_o, eng_wipe_v_o);
    end
    rr_m = ~own;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      req_i = 2'($urandom); start_i = 2'($urandom); process_i = 2'($urandom);
      hmac_en_i = 2'($urandom); wvalid_i = 2'($urandom); wdata_i = {$urandom, $urandom};
      wmask_i = 8'($urandom); eng_done_i = 1'($urandom); eng_wready_i = 1'($urandom);
      #1;
      n_cmp++;
      if (all_outs !== '0) begin
        n_err++; $display("FAIL reset_outputs: got %h expected 0", all_outs);
      end
    end
    req_i = '0;
    clear_inputs();
    rst_ni = 1'b1;
    rr_m = 1'b0;
    tick();
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++; $display("FAIL idle_outputs: got %h expected 0", all_outs);
    end
  endtask

  task automatic test_single_job();
    apply_reset();
    do_job(2'b01, 4, 80, 0);
    req_i = '0;
  endtask

  task automatic test_isolation();
    do_job(2'b01, 6, 30, 2);
    req_i = '0;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int j = 0; j < 4; j++) do_job(2'b11, $urandom_range(1, 6), $urandom_range(20, 40), 0);
    req_i = '0;
  endtask

  task automatic test_grant_drop();
    logic own;
    own = req_i[rr_m] ? rr_m : ~rr_m;
    req_i = 2'b10;
    own = 1'b1;
    #1;
    tick();
    #1;
    n_cmp++;
    if (gnt_o !== 2'b10) begin
      n_err++; $display("FAIL drop_grant: gnt got %b expected 10", gnt_o);
    end
    req_i = 2'b00; start_i = 2'b01;
    #1;
    n_cmp++;
    if ({eng_start_o, gnt_o} !== 3'b010) begin
      n_err++; $display("FAIL drop_nonowner_start: start/gnt got %b expected 010", {eng_start_o, gnt_o});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      start_i = '0;
      #1;
      n_cmp++;
      if ({busy_o, gnt_o, eng_wipe_o, owner_o} !== 5'b0) begin
        n_err++;
        $display("FAIL drop_idle: busy/gnt/wipe/owner got %b expected 00000",
                 {busy_o, gnt_o, eng_wipe_o, owner_o});
      end
    end
    do_job(2'b11, 2, 25, 0);
    req_i = '0;
  endtask

  task automatic test_timeout();
    do_job(2'b01, 3, 150, 0);
    req_i = '0;
    do_job(2'b10, 3, TIMEOUT, 1);
    req_i = '0;
  endtask

  task automatic test_reset_mid_job();
    req_i = 2'b01;
    #1;
    tick();
    start_i = 2'b01;
    tick();
    start_i = '0;
    repeat (3) begin
      wvalid_i = 2'b11; wdata_i = {$urandom, $urandom}; eng_wready_i = 1'b1;
      tick();
    end
    req_i = 2'b11; eng_done_i = 1'b1; process_i = 2'b11; wvalid_i = 2'b11;
    #1;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (all_outs !== '0) begin
      n_err++; $display("FAIL async_reset: got %h expected 0", all_outs);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      n_cmp++;
      if (all_outs !== '0) begin
        n_err++; $display("FAIL reset_hold: got %h expected 0", all_outs);
      end
    end
    req_i = '0;
    clear_inputs();
    rst_ni = 1'b1;
    rr_m = 1'b0;
    exp_q.delete();
    tick();
    req_i = 2'b01;
    #1;
    tick();
    #1;
    n_cmp++;
    if ({gnt_o, owner_o} !== 3'b010) begin
      n_err++; $display("FAIL post_reset_grant: gnt/owner got %b expected 010", {gnt_o, owner_o});
    end
    req_i = '0;
    tick();
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL post_reset_release: busy got %b expected 0", busy_o);
    end
  endtask

  // Sequence and final report
  initial begin
    n_cmp = 0;
    n_err = 0;
    rr_m = 1'b0;
    rst_ni = 1'b0;
    req_i = '0;
    clear_inputs();
    test_reset();
    test_single_job();
    test_isolation();
    test_back_to_back();
    test_grant_drop();
    test_timeout();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
